msg_rom_streamer: RTL

MSG_ROM_STREAMER -- requirements
Module: msg_rom_streamer

---
 rtl/msg_rom_streamer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/msg_rom_streamer.sv
// Streams a fixed ROM message ("ASSIGNMENT") one character per transfer over a
// valid/ready handshake, with optional looping, abort and a completed-pass counter.
module msg_rom_streamer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned MSG_LEN = 10,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              loop,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [7:0]        pass_cnt
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(MSG_LEN - 1);

    typedef enum logic [0:0] {
        StIdle,
        StStream
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              done_q, done_d;
    logic [7:0]        pass_q, pass_d;

    logic xfer;
    logic at_last;

    // Character ROM; anything past the message text reads as zero.
    function automatic logic [DATA_W-1:0] rom_char(input logic [ADDR_W-1:0] a);
        logic [31:0] c;
        case (int'(a))
            0:       c = 32'h41;
            1:       c = 32'h53;
            2:       c = 32'h53;
            3:       c = 32'h49;
            4:       c = 32'h47;
            5:       c = 32'h4E;
            6:       c = 32'h4D;
            7:       c = 32'h45;
            8:       c = 32'h4E;
            9:       c = 32'h54;
            default: c = 32'h00;
        endcase
        return DATA_W'(c);
    endfunction

    // State, index, done pulse and pass counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign xfer    = (state_q == StStream) && out_ready;
    assign at_last = (idx_q == LastIdx);

    // Next-state logic; abort outranks any transfer in the same cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StStream;
                    idx_d   = '0;
                end
            end
            StStream: begin
                if (abort) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else if (xfer) begin
                    if (at_last) begin
                        pass_d = pass_q + 8'd1;
                        idx_d  = '0;
                        if (!loop) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs come straight from registered state; data is a direct ROM read.
    always_comb begin
        out_valid = (state_q == StStream);
        busy      = (state_q == StStream);
        out_idx   = idx_q;
        out_data  = rom_char(idx_q);
        out_last  = (state_q == StStream) && at_last;
        done      = done_q;
        pass_cnt  = pass_q;
    end

endmodule
